// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, runs single-outstanding
// req/gnt/rvalid transactions on the instruction bus, and buffers returned
// words in an output register backed by a one-entry skid for IF/ID.
module inst_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] INST_NOP_W = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [2:0]  hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        fetch_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        kill_q, kill_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_addr_q, skid_addr_d;

  logic        hold_en;
  logic        consume;
  logic        gnt_ok;
  logic        rsp_ok;
  logic        deliver;
  logic [31:0] jump_target;

  // Handshake qualifiers shared by the FSM and the output stage
  always_comb begin
    hold_en     = (hold_flag_i != 3'd0);
    consume     = out_valid_q && !hold_en && !jump_flag_i;
    jump_target = jump_addr_i & ~32'h0000_0003;
    // A full skid means nowhere to put another word, so stop requesting.
    ibus_req_o  = (state_q == S_REQ) && !skid_valid_q;
    ibus_addr_o = pc_q;
    gnt_ok      = ibus_req_o && ibus_gnt_i;
    rsp_ok      = (state_q == S_WAIT) && ibus_rvalid_i;
    // Killed responses and responses racing a redirect are discarded.
    deliver     = rsp_ok && !kill_q && !jump_flag_i;
  end

  // Bus FSM and PC next-state; a redirect always overrides the PC
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (gnt_ok) begin
          state_d    = S_WAIT;
          pc_d       = pc_q + 32'd4;
          req_addr_d = pc_q;
          // Granted in the redirect cycle: the word in flight is stale.
          kill_d     = jump_flag_i;
        end
      end
      S_WAIT: begin
        if (rsp_ok) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end else if (jump_flag_i) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (jump_flag_i) begin
      pc_d = jump_target;
    end
  end

  // Output register / skid next-state: flush on redirect, refill on consume
  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_addr_d   = out_addr_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_addr_d  = skid_addr_q;
    if (jump_flag_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_inst_d   = skid_inst_q;
        out_addr_d   = skid_addr_q;
        skid_valid_d = deliver;
        if (deliver) begin
          skid_inst_d = ibus_rdata_i;
          skid_addr_d = req_addr_q;
        end
      end else if (deliver) begin
        out_valid_d = 1'b1;
        out_inst_d  = ibus_rdata_i;
        out_addr_d  = req_addr_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (deliver) begin
      if (out_valid_q) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = ibus_rdata_i;
        skid_addr_d  = req_addr_q;
      end else begin
        out_valid_d = 1'b1;
        out_inst_d  = ibus_rdata_i;
        out_addr_d  = req_addr_q;
      end
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_ADDR;
      kill_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Data registers; only meaningful while their valid flag is set
  always_ff @(posedge clk) begin
    req_addr_q  <= req_addr_d;
    out_inst_q  <= out_inst_d;
    out_addr_q  <= out_addr_d;
    skid_inst_q <= skid_inst_d;
    skid_addr_q <= skid_addr_d;
  end

  // IF/ID sees a NOP bubble whenever nothing valid is buffered
  always_comb begin
    inst_o       = out_valid_q ? out_inst_q : INST_NOP_W;
    inst_addr_o  = out_valid_q ? out_addr_q : 32'h0000_0000;
    fetch_busy_o = !out_valid_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Cycle-by-cycle directed bench for inst_fetch with a 1-cycle-latency
// instruction memory whose grant and response can be switched per cycle.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [2:0]  hold_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        fetch_busy_o;

  logic        gnt_en = 1'b0;
  logic        rsp_en = 1'b0;
  logic        pend   = 1'b0;
  logic [31:0] paddr  = 32'h0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .fetch_busy_o  (fetch_busy_o)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  assign ibus_gnt_i    = gnt_en;
  assign ibus_rvalid_i = pend && rsp_en;
  assign ibus_rdata_i  = memword(paddr);

  // Memory: accepts a request when granted, answers the next cycle rsp_en allows
  always @(posedge clk) begin
    if (ibus_rvalid_i) pend <= 1'b0;
    if (ibus_req_o === 1'b1 && gnt_en) begin
      pend  <= 1'b1;
      paddr <= ibus_addr_o;
    end
  end

  typedef struct {
    bit          rst;
    logic [2:0]  hold;
    bit          jmp;
    logic [31:0] jaddr;
    bit          gnt;
    bit          rsp;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_vld;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input int h, input bit j, input logic [31:0] ja,
                     input bit g, input bit s, input bit er, input logic [31:0] ea,
                     input bit ev, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.hold = h[2:0]; v.jmp = j; v.jaddr = ja; v.gnt = g; v.rsp = s;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_iaddr = ei;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks every visible output against the expected request and output state
  task automatic chk_outs(input string tag, input bit er, input logic [31:0] ea,
                          input bit ev, input logic [31:0] ei);
    chk({tag, " req"}, {31'b0, ibus_req_o}, {31'b0, er});
    if (er) chk({tag, " req_addr"}, ibus_addr_o, ea);
    chk({tag, " busy"}, {31'b0, fetch_busy_o}, {31'b0, !ev});
    chk({tag, " inst_addr"}, inst_addr_o, ev ? ei : 32'h0);
    chk({tag, " inst"}, inst_o, ev ? memword(ei) : 32'h0000_0013);
  endtask

  task automatic drive(input bit r, input logic [2:0] h, input bit j,
                       input logic [31:0] ja, input bit g, input bit s);
    @(negedge clk);
    rst = r; hold_flag_i = h; jump_flag_i = j; jump_addr_i = ja;
    gnt_en = g; rsp_en = s;
    #1;
  endtask

  initial begin
    rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 3'd0;
    repeat (2) @(posedge clk);

    // Reset, first fetch and release bubble
    add(0,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    // Sequential stream 0x0..0x1C, one word per two cycles
    for (int k = 4; k <= 18; k++) begin
      if (k % 2 == 0) add(1,0,0,32'h0,1,1, 1,32'(4*(k/2-1)),1,32'(4*(k/2-2)));
      else            add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    end
    // Hold_If for five cycles: output frozen, skid fills, req gated
    add(1,2,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,2,0,32'h0,1,1, 1,32'h24,1,32'h20);
    add(1,2,0,32'h0,1,1, 0,32'h0,1,32'h20);
    add(1,2,0,32'h0,1,1, 0,32'h0,1,32'h20);
    add(1,2,0,32'h0,1,1, 0,32'h0,1,32'h20);
    add(1,0,0,32'h0,1,1, 0,32'h0,1,32'h20);
    add(1,0,0,32'h0,1,1, 1,32'h28,1,32'h24);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h2C,1,32'h28);
    // Jump during WAIT, stale response arrives afterwards
    add(1,0,1,32'h103,1,0, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h100,0,32'h0);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h104,1,32'h100);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    // Jump in the grant cycle, then jump in the rvalid cycle
    add(1,0,1,32'h200,1,1, 1,32'h108,1,32'h104);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h200,0,32'h0);
    add(1,0,1,32'h300,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h300,0,32'h0);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    // Ungranted jump to the top word, then PC wrap to zero
    add(1,0,1,32'hFFFF_FFFE,0,1, 1,32'h304,1,32'h300);
    add(1,0,0,32'h0,1,1, 1,32'hFFFF_FFFC,0,32'h0);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h0,1,32'hFFFF_FFFC);
    // Reset mid-WAIT, late rvalid while IDLE, restart at RESET_ADDR
    add(1,0,0,32'h0,1,0, 0,32'h0,0,32'h0);
    add(0,0,0,32'h0,1,0, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 0,32'h0,0,32'h0);
    add(1,0,0,32'h0,1,1, 1,32'h4,1,32'h0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].hold, vq[i].jmp, vq[i].jaddr, vq[i].gnt, vq[i].rsp);
      chk_outs($sformatf("row%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_vld, vq[i].e_iaddr);
    end

    // Hold_Pc and Hold_Id levels also freeze the output and gate requests
    drive(1, 3'd1, 0, 32'h0, 1, 1); chk_outs("hpc0", 0, 32'h0, 0, 32'h0);
    drive(1, 3'd1, 0, 32'h0, 1, 1); chk_outs("hpc1", 1, 32'h8, 1, 32'h4);
    drive(1, 3'd3, 0, 32'h0, 1, 1); chk_outs("hid0", 0, 32'h0, 1, 32'h4);
    drive(1, 3'd3, 0, 32'h0, 1, 1); chk_outs("hid1", 0, 32'h0, 1, 32'h4);
    drive(1, 3'd0, 0, 32'h0, 1, 1); chk_outs("rel0", 0, 32'h0, 1, 32'h4);
    drive(1, 3'd0, 0, 32'h0, 1, 1); chk_outs("rel1", 1, 32'hC, 1, 32'h8);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
